// File: rtl/cubed_pkg.sv
// Shared definitions for the framebuffer / DDRAM write path.
// Contents: DDRAM word-address width, framebuffer geometry, the buffered
// beat payload (data + byte enables) and the burst packer state encoding.
package cubed_pkg;

    localparam int unsigned DDR_AW          = 29;
    localparam logic [DDR_AW-1:0] FB_BASE   = 29'h0600_0000;
    localparam int unsigned FB_STRIDE_WORDS = 320;

    // One buffered beat: 64 data bits plus 8 byte enables.
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  be;
    } ddr_word_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_BURST = 2'd2
    } packer_state_t;

endpackage

// File: rtl/burst_buf.sv
// Burst staging register file: DEPTH entries of ddr_word_t.
// Ports: clk; wr_en/wr_idx/wr_data synchronous write; rd_idx/rd_data
// asynchronous read so each beat is available without read latency.
module burst_buf
    import cubed_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  ddr_word_t                wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output ddr_word_t                rd_data
);

    ddr_word_t mem [DEPTH];

    // Contents need no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ddram_burst_packer.sv
// Write-combining stage between the tile writer and the DDRAM controller.
// Gathers address-contiguous single-word writes and issues them as one burst.
// Ports: clk, reset_n (async active-low); in_* tile-writer req/ack side;
// flush drain request; ddr_* burst master side; idle status.
// Option: DDRAM_BURST_PACKER_TIMEOUT_EN drains a partial buffer after
// TIMEOUT cycles without an accepted word.
module ddram_burst_packer
    import cubed_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DDR_AW-1:0] in_addr,
    input  logic [7:0]        in_burstcnt,
    input  logic [63:0]       in_data,
    input  logic [7:0]        in_be,
    input  logic              in_req,
    output logic              in_ack,
    output logic              in_busy,
    input  logic              flush,
    output logic [DDR_AW-1:0] ddr_addr,
    output logic [7:0]        ddr_burstcnt,
    output logic [63:0]       ddr_din,
    output logic [7:0]        ddr_be,
    output logic              ddr_we,
    input  logic              ddr_busy,
    output logic              idle
);

    localparam int unsigned IW = $clog2(MAX_BURST);
    localparam int unsigned CW = IW + 1;

    packer_state_t     state, state_nxt;
    logic [DDR_AW-1:0] base, base_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [IW-1:0]     beat, beat_nxt;
    logic              hold, hold_nxt;
    logic              in_ack_nxt;
    logic [DDR_AW-1:0] ddr_addr_nxt;
    logic [7:0]        ddr_burstcnt_nxt;
    logic [63:0]       ddr_din_nxt;
    logic [7:0]        ddr_be_nxt;
    logic              ddr_we_nxt;
    logic              accept;
    logic              go_burst;
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    ddr_word_t         wr_data;
    ddr_word_t         rd_data;

`ifdef DDRAM_BURST_PACKER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt, idle_cnt_nxt;
    logic          unused_cfg;
    assign unused_cfg = ^in_burstcnt;
`else
    logic          unused_cfg;
    assign unused_cfg = ^{in_burstcnt, 32'(TIMEOUT)};
`endif

    assign wr_data = '{data: in_data, be: in_be};
    // Outside a burst the read port points at entry 0 for the first beat;
    // during a burst it looks one entry ahead so the next beat loads on the
    // same edge that completes the current one.
    assign rd_idx  = (state == S_BURST) ? beat + IW'(1) : '0;

    burst_buf #(.DEPTH(MAX_BURST)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt        = state;
        base_nxt         = base;
        count_nxt        = count;
        beat_nxt         = beat;
        hold_nxt         = 1'b0;
        in_ack_nxt       = 1'b0;
        ddr_addr_nxt     = ddr_addr;
        ddr_burstcnt_nxt = ddr_burstcnt;
        ddr_din_nxt      = ddr_din;
        ddr_be_nxt       = ddr_be;
        ddr_we_nxt       = ddr_we;
        accept           = 1'b0;
        go_burst         = 1'b0;
        wr_en            = 1'b0;
        wr_idx           = '0;
`ifdef DDRAM_BURST_PACKER_TIMEOUT_EN
        idle_cnt_nxt     = '0;
`endif
        case (state)
            S_EMPTY: begin
                if (in_req && !hold) begin
                    accept    = 1'b1;
                    wr_en     = 1'b1;
                    base_nxt  = in_addr;
                    count_nxt = CW'(1);
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (in_req && !hold) begin
                    if (in_addr == base + DDR_AW'(count)) begin
                        accept    = 1'b1;
                        wr_en     = 1'b1;
                        wr_idx    = IW'(count);
                        count_nxt = count + CW'(1);
                        if (count_nxt == CW'(MAX_BURST)) begin
                            go_burst = 1'b1;
                        end
                    end else begin
                        // Run broken: drain first, the word is taken afterwards.
                        go_burst = 1'b1;
                    end
                end
                if (flush) begin
                    go_burst = 1'b1;
                end
`ifdef DDRAM_BURST_PACKER_TIMEOUT_EN
                if (!accept) begin
                    if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        go_burst = 1'b1;
                    end else begin
                        idle_cnt_nxt = idle_cnt + TW'(1);
                    end
                end
`endif
                if (go_burst) begin
                    state_nxt        = S_BURST;
                    beat_nxt         = '0;
                    ddr_we_nxt       = 1'b1;
                    ddr_addr_nxt     = base;
                    ddr_burstcnt_nxt = 8'(count_nxt);
                    ddr_din_nxt      = rd_data.data;
                    ddr_be_nxt       = rd_data.be;
                end
            end
            S_BURST: begin
                if (ddr_we && !ddr_busy) begin
                    if (CW'(beat) == count - CW'(1)) begin
                        state_nxt  = S_EMPTY;
                        count_nxt  = '0;
                        beat_nxt   = '0;
                        ddr_we_nxt = 1'b0;
                    end else begin
                        beat_nxt    = beat + IW'(1);
                        ddr_din_nxt = rd_data.data;
                        ddr_be_nxt  = rd_data.be;
                    end
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
        if (accept) begin
            in_ack_nxt = 1'b1;
            hold_nxt   = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_EMPTY;
            base         <= '0;
            count        <= '0;
            beat         <= '0;
            hold         <= 1'b0;
            in_ack       <= 1'b0;
            in_busy      <= 1'b0;
            idle         <= 1'b1;
            ddr_addr     <= '0;
            ddr_burstcnt <= '0;
            ddr_din      <= '0;
            ddr_be       <= '0;
            ddr_we       <= 1'b0;
`ifdef DDRAM_BURST_PACKER_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            base         <= base_nxt;
            count        <= count_nxt;
            beat         <= beat_nxt;
            hold         <= hold_nxt;
            in_ack       <= in_ack_nxt;
            in_busy      <= (state_nxt == S_BURST);
            idle         <= (state_nxt == S_EMPTY);
            ddr_addr     <= ddr_addr_nxt;
            ddr_burstcnt <= ddr_burstcnt_nxt;
            ddr_din      <= ddr_din_nxt;
            ddr_be       <= ddr_be_nxt;
            ddr_we       <= ddr_we_nxt;
`ifdef DDRAM_BURST_PACKER_TIMEOUT_EN
            idle_cnt     <= idle_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ddram_burst_packer.sv
// Directed self-checking bench for ddram_burst_packer.
module tb_ddram_burst_packer;
    import cubed_pkg::*;

    localparam logic [28:0] BASE = 29'h0600_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [28:0] in_addr;
    logic [7:0]  in_burstcnt;
    logic [63:0] in_data;
    logic [7:0]  in_be;
    logic        in_req;
    logic        in_ack;
    logic        in_busy;
    logic        flush;
    logic [28:0] ddr_addr;
    logic [7:0]  ddr_burstcnt;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic        ddr_we;
    logic        ddr_busy;
    logic        idle;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [63:0] beat_data [$];
    logic [28:0] beat_addr [$];
    logic [7:0]  beat_cnt  [$];
    int          beat_cyc  [$];
    int          ack_cyc   [$];

    always #5 clk = ~clk;

    ddram_burst_packer #(.MAX_BURST(16), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_addr      (in_addr),
        .in_burstcnt  (in_burstcnt),
        .in_data      (in_data),
        .in_be        (in_be),
        .in_req       (in_req),
        .in_ack       (in_ack),
        .in_busy      (in_busy),
        .flush        (flush),
        .ddr_addr     (ddr_addr),
        .ddr_burstcnt (ddr_burstcnt),
        .ddr_din      (ddr_din),
        .ddr_be       (ddr_be),
        .ddr_we       (ddr_we),
        .ddr_busy     (ddr_busy),
        .idle         (idle)
    );

    // Capture accepted beats and acks as they happen.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && ddr_we && !ddr_busy) begin
            beat_data.push_back(ddr_din);
            beat_addr.push_back(ddr_addr);
            beat_cnt.push_back(ddr_burstcnt);
            beat_cyc.push_back(cyc);
        end
        if (reset_n && in_ack) begin
            ack_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        beat_data.delete();
        beat_addr.delete();
        beat_cnt.delete();
        beat_cyc.delete();
        ack_cyc.delete();
    endtask

    // Present one word; keep in_req up for one cycle after the ack.
    task automatic send_word(input logic [28:0] a, input logic [63:0] d, input logic fl);
        logic ok;
        ok      = 1'b0;
        in_addr = a;
        in_data = d;
        in_be   = 8'hFF;
        in_req  = 1'b1;
        flush   = fl;
        for (int n = 0; n < 300; n++) begin
            tick();
            flush = 1'b0;
            if (in_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL ack_timeout addr=%h: no in_ack within 300 cycles", a);
        end
        tick();
        in_req = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (idle && !ddr_we && !in_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: idle=%b ddr_we=%b after 300 cycles", idle, ddr_we);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ddr_we !== 1'b0 || in_ack !== 1'b0 || in_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: we=%b ack=%b busy=%b expected 0 0 0", ddr_we, in_ack, in_busy);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 1", idle);
        end
        checks++;
        if (ddr_addr !== 29'd0 || ddr_burstcnt !== 8'd0 || ddr_din !== 64'd0 || ddr_be !== 8'd0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h cnt=%0d din=%h be=%h expected zeros",
                     ddr_addr, ddr_burstcnt, ddr_din, ddr_be);
        end
    endtask

    task automatic test_full_burst();
        clear_log();
        for (int i = 0; i < 16; i++) send_word(BASE + 29'(i), 64'(i), 1'b0);
        wait_idle();
        checks++;
        if (ack_cyc.size() != 16) begin
            errors++;
            $display("FAIL full_acks: got %0d expected 16", ack_cyc.size());
        end
        checks++;
        if (beat_data.size() != 16) begin
            errors++;
            $display("FAIL full_beats: got %0d expected 16", beat_data.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (beat_data[i] !== 64'(i) || beat_addr[i] !== BASE || beat_cnt[i] !== 8'd16) begin
                    errors++;
                    $display("FAIL full_beat%0d: data=%h addr=%h cnt=%0d expected %h %h 16",
                             i, beat_data[i], beat_addr[i], beat_cnt[i], 64'(i), BASE);
                end
            end
        end
    endtask

    task automatic test_noncontig();
        clear_log();
        for (int i = 0; i < 5; i++) send_word(BASE + 29'(i), 64'h200 + 64'(i), 1'b0);
        send_word(BASE + 29'h140, 64'h2FF, 1'b0);
        checks++;
        if (beat_data.size() != 5) begin
            errors++;
            $display("FAIL nc_first_burst: got %0d beats expected 5", beat_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (beat_data[i] !== 64'h200 + 64'(i) || beat_cnt[i] !== 8'd5 || beat_addr[i] !== BASE) begin
                    errors++;
                    $display("FAIL nc_beat%0d: data=%h cnt=%0d addr=%h expected %h 5 %h",
                             i, beat_data[i], beat_cnt[i], beat_addr[i], 64'h200 + 64'(i), BASE);
                end
            end
            checks++;
            if (ack_cyc.size() != 6 || ack_cyc[ack_cyc.size()-1] < beat_cyc[4] + 2) begin
                errors++;
                $display("FAIL nc_ack_order: acks=%0d last_ack=%0d last_beat=%0d expected 6 acks, ack >= beat+2",
                         ack_cyc.size(), ack_cyc[ack_cyc.size()-1], beat_cyc[4]);
            end
        end
        pulse_flush();
        wait_idle();
        checks++;
        if (beat_data.size() != 6) begin
            errors++;
            $display("FAIL nc_second_burst: got %0d beats expected 6", beat_data.size());
        end else if (beat_data[5] !== 64'h2FF || beat_addr[5] !== BASE + 29'h140 || beat_cnt[5] !== 8'd1) begin
            errors++;
            $display("FAIL nc_second_beat: data=%h addr=%h cnt=%0d expected 2ff %h 1",
                     beat_data[5], beat_addr[5], beat_cnt[5], BASE + 29'h140);
        end
    endtask

    task automatic test_flush();
        clear_log();
        send_word(BASE + 29'h20, 64'h300, 1'b0);
        send_word(BASE + 29'h21, 64'h301, 1'b0);
        send_word(BASE + 29'h22, 64'h302, 1'b1);
        wait_idle();
        checks++;
        if (beat_data.size() != 3) begin
            errors++;
            $display("FAIL flush_beats: got %0d expected 3", beat_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beat_data[i] !== 64'h300 + 64'(i) || beat_cnt[i] !== 8'd3 || beat_addr[i] !== BASE + 29'h20) begin
                    errors++;
                    $display("FAIL flush_beat%0d: data=%h cnt=%0d addr=%h expected %h 3 %h",
                             i, beat_data[i], beat_cnt[i], beat_addr[i], 64'h300 + 64'(i), BASE + 29'h20);
                end
            end
        end
    endtask

    task automatic test_busy_stall();
        logic s7, s15;
        int   k;
        s7  = 1'b0;
        s15 = 1'b0;
        clear_log();
        ddr_busy = 1'b0;
        for (int i = 0; i < 15; i++) send_word(BASE + 29'h40 + 29'(i), 64'h100 + 64'(i), 1'b0);
        ddr_busy = 1'b1;
        send_word(BASE + 29'h4F, 64'h10F, 1'b0);
        tick();
        checks++;
        if (ddr_we !== 1'b1 || ddr_din !== 64'h100 || ddr_addr !== BASE + 29'h40 ||
            ddr_burstcnt !== 8'd16 || beat_data.size() != 0) begin
            errors++;
            $display("FAIL stall_beat0: we=%b din=%h addr=%h cnt=%0d taken=%0d expected 1 100 %h 16 0",
                     ddr_we, ddr_din, ddr_addr, ddr_burstcnt, beat_data.size(), BASE + 29'h40);
        end
        ddr_busy = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!ddr_we) break;
            k = beat_data.size();
            if ((k == 7 && !s7) || (k == 15 && !s15)) begin
                if (k == 7) s7 = 1'b1;
                else s15 = 1'b1;
                ddr_busy = 1'b1;
                tick();
                tick();
                tick();
                checks++;
                if (ddr_we !== 1'b1 || ddr_din !== 64'h100 + 64'(k) || beat_data.size() != k) begin
                    errors++;
                    $display("FAIL stall_beat%0d: we=%b din=%h taken=%0d expected 1 %h %0d",
                             k, ddr_we, ddr_din, beat_data.size(), 64'h100 + 64'(k), k);
                end
                ddr_busy = 1'b0;
            end
            tick();
        end
        wait_idle();
        checks++;
        if (beat_data.size() != 16) begin
            errors++;
            $display("FAIL stall_beats: got %0d expected 16", beat_data.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (beat_data[i] !== 64'h100 + 64'(i)) begin
                    errors++;
                    $display("FAIL stall_order%0d: got %h expected %h", i, beat_data[i], 64'h100 + 64'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic hit;
        hit = 1'b0;
        clear_log();
        for (int i = 0; i < 16; i++) send_word(BASE + 29'h400 + 29'(i), 64'h500 + 64'(i), 1'b0);
        for (int n = 0; n < 100; n++) begin
            if (beat_data.size() >= 8) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit || beat_data.size() != 8) begin
            errors++;
            $display("FAIL rst_reach_beat8: taken=%0d expected 8", beat_data.size());
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ddr_we !== 1'b0 || in_busy !== 1'b0 || ddr_burstcnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_async: we=%b busy=%b cnt=%0d expected 0 0 0", ddr_we, in_busy, ddr_burstcnt);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (idle !== 1'b1 || ddr_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: idle=%b we=%b expected 1 0", idle, ddr_we);
        end
        clear_log();
        send_word(BASE + 29'h200, 64'hABCD, 1'b0);
        pulse_flush();
        wait_idle();
        checks++;
        if (beat_data.size() != 1) begin
            errors++;
            $display("FAIL rst_fresh_beats: got %0d expected 1", beat_data.size());
        end else if (beat_data[0] !== 64'hABCD || beat_addr[0] !== BASE + 29'h200 || beat_cnt[0] !== 8'd1) begin
            errors++;
            $display("FAIL rst_fresh_beat: data=%h addr=%h cnt=%0d expected abcd %h 1",
                     beat_data[0], beat_addr[0], beat_cnt[0], BASE + 29'h200);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        in_addr     = '0;
        in_burstcnt = 8'd1;
        in_data     = '0;
        in_be       = '0;
        in_req      = 1'b0;
        flush       = 1'b0;
        ddr_busy    = 1'b0;
        tick();
        tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_full_burst();
        test_noncontig();
        test_flush();
        test_busy_stall();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddram_burst_packer.md
# ddram_burst_packer

Write-combining stage between the tile writer and the DDRAM controller. Accepts single-word 64-bit framebuffer writes over the tile writer's req/ack interface and gathers address-contiguous words into one buffer. Issues each run as a single DDRAM burst of up to `MAX_BURST` beats, so each 32-pixel tile row (16 contiguous words) leaves as one burst instead of 16.

## Interface
Parameters:
- `MAX_BURST`, 16: buffer depth and maximum burst length; legal range 2..128.
- `TIMEOUT`, 64: idle cycles before an automatic flush (only with `DDRAM_BURST_PACKER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_addr`  in  29  64-bit word address.
- `in_burstcnt`  in  8  ignored; every request is one word.
- `in_data`  in  64  write data.
- `in_be`  in  8  byte enables.
- `in_req`  in  1  write request, held until acked.
- `in_ack`  out  1  registered one-cycle pulse; the word has been captured.
- `in_busy`  out  1  high while the block is bursting or cannot accept.
- `flush`  in  1  one-cycle pulse; drain the buffer now.
- `ddr_addr`  out  29  burst start address.
- `ddr_burstcnt`  out  8  beats in the burst.
- `ddr_din`  out  64  beat data.
- `ddr_be`  out  8  beat byte enables.
- `ddr_we`  out  1  beat valid.
- `ddr_busy`  in  1  controller waitrequest.
- `idle`  out  1  high when the buffer is empty and no burst is in flight.

## Operation
- State machine: S_EMPTY, S_FILL, S_BURST.
- Internal registers:
  - `base`: 29-bit address of buffer entry 0.
  - `count`: 0..`MAX_BURST`, width $clog2(`MAX_BURST`)+1.
  - `beat`: burst beat index.
  - `hold`: one-cycle ack holdoff.
- S_EMPTY with `in_req` and `!hold`:
  - store the word at entry 0, `base`<=`in_addr`, `count`<=1, pulse `in_ack`, go to S_FILL.
- S_FILL with `in_req` and `!hold`:
  - Contiguous word (`in_addr == base + count`, 29-bit modulo): store at entry `count`, increment `count`, pulse `in_ack`.
  - If `count` reaches `MAX_BURST`, go to S_BURST.
  - Non-contiguous word: do not ack; go to S_BURST. The word is taken from S_EMPTY after the drain.
- `hold` is set the cycle `in_ack` is high. The upstream may keep `in_req` high for one cycle after ack, and that cycle is never taken as a new request.
- `flush` in S_FILL: go to S_BURST.
  - `flush` together with an accepted contiguous word: the word is captured first and included in the burst.
  - `flush` in S_EMPTY or S_BURST: ignored.
- S_BURST:
  - `ddr_addr`=`base`, `ddr_burstcnt`=`count`, `ddr_we`=1, `ddr_din`/`ddr_be`=entry `beat`.
  - `beat` advances on each cycle with `ddr_we && !ddr_busy`.
  - After the final beat is accepted: `count`<=0, `ddr_we`<=0, go to S_EMPTY.
  - `ddr_addr`/`ddr_burstcnt` stay stable for the whole burst.
- `in_busy` = (state==S_BURST). `idle` = (state==S_EMPTY).
- Reset (async, any state, including mid-burst): buffer contents discarded, state S_EMPTY.
- Reset values: `ddr_we`, `in_ack`, `in_busy`=0; `idle`=1; `ddr_addr`, `ddr_burstcnt`, `ddr_din`, `ddr_be`=0.

## Timing
- Word acceptance: `in_ack` is high the cycle after `in_req` is sampled; at most one word every 2 cycles, because of the holdoff.
- S_FILL to S_BURST: first beat (`ddr_we`=1) on the cycle after the transition.
- Bursting: one beat per cycle with `ddr_busy` low, no bubbles. Beat outputs are registered and the next entry loads in the same edge that completes the current beat.
- A `ddr_busy` stall holds all `ddr_*` outputs unchanged.
- Burst end to next acceptance: S_EMPTY on the edge after the last beat, so the earliest next `in_ack` comes 2 cycles after the last beat.

## Configuration
- `DDRAM_BURST_PACKER_TIMEOUT_EN` defined: in S_FILL, a counter resets on each accepted word. When it reaches `TIMEOUT` idle cycles, the block enters S_BURST as if `flush` had arrived.
- Undefined: no counter. Partial buffers drain only on full, non-contiguous address, or `flush`.

## Structure
- Shared package `cubed_pkg`:
  - `DDR_AW`=29, `FB_BASE`, `FB_STRIDE_WORDS`=320.
  - the `ddr_word_t` typedef (64 data + 8 be).
  - the state enum.
- One sub-module, `burst_buf`: a `MAX_BURST`×72 register file with a synchronous write port and an asynchronous read port, so bursts run without read latency.

## Test plan
- 16 contiguous words from 0x06000000, data = index → one burst: `ddr_addr`=0x06000000, `ddr_burstcnt`=16, beats 0..15 in order; `in_ack` ×16.
- 5 words at 0x06000000..04, then one at 0x06000140 → 5-beat burst first; 0x06000140 acked only after the burst.
- `flush` together with the 3rd contiguous word → 3-beat burst that includes the word.
- `ddr_busy` high on beats 0, 7 and 15 for 3 cycles each → outputs held, burst completes, no beat lost or duplicated.
- `in_req` kept high for one cycle after each ack → no duplicate capture; `count` equals the number of acks.
- `reset_n` low at beat 8 of 16 → `ddr_we`=0 immediately, `idle`=1 after release, the next word starts a fresh buffer.
